// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   Pipeline MEM stage. Holds the EX/MEM pipeline register, runs byte/half/word
//   loads and stores over a ready-handshaked data-memory port, aligns and
//   extends load data, stalls upstream while an access is outstanding and
//   hands bubbles to write-back while stalled or after a timed-out access.
//
//   Memory handshake: mem_req is held high with address, write strobe, byte
//   enables and write data stable until the cycle in which mem_ready=1; that
//   cycle completes the access (mem_rdata valid in that same cycle). If
//   mem_ready does not arrive within TIMEOUT request cycles the access is
//   abandoned, mem_fault is set (sticky until reset) and a bubble is issued.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   d*                         instruction fields from EX
//   stall                      holds upstream stages and the EX/MEM register
//   mem_req/we/addr/be/wdata   data-memory request
//   mem_ready/rdata            data-memory response
//   mem2reg/regwr/rw/dmem/     fields to the write-back register
//   execresult
//   misalign                   one-cycle pulse for a misaligned half/word op
//   mem_fault                  sticky access-timeout flag
//   dbg_state                  FSM state (0 = IDLE, 1 = WAIT)
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem2reg,
  input  logic        dregwr,
  input  logic [4:0]  drw,
  input  logic        dmemrd,
  input  logic        dmemwr,
  input  logic [1:0]  dsize,
  input  logic        dsigned,
  input  logic [31:0] dexecresult,
  input  logic [31:0] dstoredata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem2reg,
  output logic        regwr,
  output logic [4:0]  rw,
  output logic [31:0] dmem,
  output logic [31:0] execresult,
  output logic        misalign,
  output logic        mem_fault,
  output logic        dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  // EX/MEM pipeline register
  logic        mem2reg_q;
  logic        regwr_q;
  logic [4:0]  rw_q;
  logic        memrd_q;
  logic        memwr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] exec_q;
  logic [31:0] sdata_q;

  // Access FSM
  state_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;

  logic        is_byte, is_half, is_word;
  logic [1:0]  addr_lo;
  logic        misalign_c;
  logic        mop;
  logic        timeout_hit;
  logic        complete;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem2reg_q <= 1'b0;
      regwr_q   <= 1'b0;
      rw_q      <= 5'd0;
      memrd_q   <= 1'b0;
      memwr_q   <= 1'b0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      exec_q    <= 32'd0;
      sdata_q   <= 32'd0;
    end else if (!stall) begin
      mem2reg_q <= dmem2reg;
      regwr_q   <= dregwr;
      rw_q      <= drw;
      memrd_q   <= dmemrd;
      memwr_q   <= dmemwr;
      size_q    <= dsize;
      signed_q  <= dsigned;
      exec_q    <= dexecresult;
      sdata_q   <= dstoredata;
    end
  end

  // Size 2'b11 is treated as a word access.
  assign is_byte = (size_q == 2'b00);
  assign is_half = (size_q == 2'b01);
  assign is_word = size_q[1];
  assign addr_lo = exec_q[1:0];

  assign misalign_c = (memrd_q | memwr_q) &
                      ((is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00)));
  assign mop = (memrd_q | memwr_q) & ~misalign_c;

  // The IDLE request cycle counts as wait cycle 0, so WAIT starts at 1 and the
  // access is given TIMEOUT request cycles in total before being abandoned.
  assign timeout_hit = (state_q == S_WAIT) & ~mem_ready & (cnt_q == CW'(TIMEOUT - 1));
  assign stall       = mop & ~mem_ready & ~timeout_hit;
  assign complete    = mop & mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q | timeout_hit;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (mop && !mem_ready) begin
          state_d = S_WAIT;
          cnt_d   = CW'(1);
        end
      end
      S_WAIT: begin
        if (mem_ready || timeout_hit) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = sdata_q;
    if (is_byte) begin
      be_c    = 4'b0001 << addr_lo;
      wdata_c = {4{sdata_q[7:0]}};
    end else if (is_half) begin
      be_c    = 4'b0011 << addr_lo;
      wdata_c = {2{sdata_q[15:0]}};
    end
  end

  // Load lane select and extension
  always_comb begin
    lane_byte = mem_rdata[7:0];
    case (addr_lo)
      2'b00:   lane_byte = mem_rdata[7:0];
      2'b01:   lane_byte = mem_rdata[15:8];
      2'b10:   lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (is_byte) begin
      load_ext = signed_q ? {{24{lane_byte[7]}}, lane_byte} : {24'd0, lane_byte};
    end else if (is_half) begin
      load_ext = signed_q ? {{16{lane_half[15]}}, lane_half} : {16'd0, lane_half};
    end else begin
      load_ext = mem_rdata;
    end
  end

  // Request side is quiet (all zero) whenever no access is being issued.
  assign mem_req   = mop;
  assign mem_we    = mop & memwr_q;
  assign mem_addr  = mop ? {exec_q[31:2], 2'b00} : 32'd0;
  assign mem_be    = mop ? be_c : 4'b0000;
  assign mem_wdata = (mop & memwr_q) ? wdata_c : 32'd0;

  // Write-back side
  assign mem2reg    = mem2reg_q & ~stall;
  assign regwr      = regwr_q & ~stall & ~misalign_c & ~timeout_hit;
  assign rw         = rw_q;
  assign execresult = exec_q;
  assign dmem       = (complete & memrd_q) ? load_ext : 32'd0;
  assign misalign   = misalign_c;
  assign mem_fault  = fault_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//   Directed bench for mem_access_stage: a table of single-instruction vectors
//   (zero-stall accesses, ALU pass-through, misaligned ops) plus hand-written
//   sequences for a delayed-ready load, an access timeout, and a reset taken
//   in the middle of a WAIT.
//   Inputs are driven on the falling edge; outputs are checked 1 time unit
//   after the falling edge, well away from the rising (active) edge.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        dmem2reg;
  logic        dregwr;
  logic [4:0]  drw;
  logic        dmemrd;
  logic        dmemwr;
  logic [1:0]  dsize;
  logic        dsigned;
  logic [31:0] dexecresult;
  logic [31:0] dstoredata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem2reg;
  logic        regwr;
  logic [4:0]  rw;
  logic [31:0] dmem;
  logic [31:0] execresult;
  logic        misalign;
  logic        mem_fault;
  logic        dbg_state;

  int n_checks;
  int n_fail;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dmem2reg    (dmem2reg),
    .dregwr      (dregwr),
    .drw         (drw),
    .dmemrd      (dmemrd),
    .dmemwr      (dmemwr),
    .dsize       (dsize),
    .dsigned     (dsigned),
    .dexecresult (dexecresult),
    .dstoredata  (dstoredata),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .mem2reg     (mem2reg),
    .regwr       (regwr),
    .rw          (rw),
    .dmem        (dmem),
    .execresult  (execresult),
    .misalign    (misalign),
    .mem_fault   (mem_fault),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- vectors
  typedef struct {
    // EX inputs
    logic        m2r;
    logic        rwe;
    logic [4:0]  rwi;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] exec;
    logic [31:0] sdata;
    // memory response in the cycle the op sits in MEM
    logic        ready;
    logic [31:0] rdata;
    // expected outputs in that cycle
    logic        x_req;
    logic        x_we;
    logic [31:0] x_addr;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
    logic        x_stall;
    logic        x_regwr;
    logic        x_m2r;
    logic [31:0] x_dmem;
    logic        x_mis;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  // ---------------------------------------------------------------- driver tasks
  task automatic drive_ex(input logic m2r, input logic rwe, input logic [4:0] rwi,
                          input logic rd, input logic wr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] exec,
                          input logic [31:0] sdata);
    dmem2reg    = m2r;
    dregwr      = rwe;
    drw         = rwi;
    dmemrd      = rd;
    dmemwr      = wr;
    dsize       = size;
    dsigned     = sgn;
    dexecresult = exec;
    dstoredata  = sdata;
  endtask

  task automatic drive_nop();
    drive_ex(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
  endtask

  // ---------------------------------------------------------------- checker
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_req"},    mem_req,    32'd0);
    check({tag, " stall"},      stall,      32'd0);
    check({tag, " mem_we"},     mem_we,     32'd0);
    check({tag, " mem_addr"},   mem_addr,   32'd0);
    check({tag, " mem_be"},     mem_be,     32'd0);
    check({tag, " mem_wdata"},  mem_wdata,  32'd0);
    check({tag, " mem2reg"},    mem2reg,    32'd0);
    check({tag, " regwr"},      regwr,      32'd0);
    check({tag, " rw"},         rw,         32'd0);
    check({tag, " dmem"},       dmem,       32'd0);
    check({tag, " execresult"}, execresult, 32'd0);
    check({tag, " misalign"},   misalign,   32'd0);
    check({tag, " mem_fault"},  mem_fault,  32'd0);
    check({tag, " dbg_state"},  dbg_state,  32'd0);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    int n_stall;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    drive_nop();

    //            m2r rwe rw  rd wr size   sgn exec          sdata         rdy rdata
    //            | req we addr          be       wdata         stl rwe m2r dmem          mis
    vecs[0]  = '{1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0,         1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 1'b1, 32'h0,
                 1'b1, 1'b1, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[2]  = '{1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0301, 32'h0,         1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         1'b1};
    vecs[3]  = '{1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0106, 32'h0,         1'b1, 32'hABCD_1234,
                 1'b1, 1'b0, 32'h0000_0104, 4'b1100, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_ABCD, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0104, 32'h0,         1'b1, 32'h1234_8765,
                 1'b1, 1'b0, 32'h0000_0104, 4'b0011, 32'h0,         1'b0, 1'b1, 1'b1, 32'hFFFF_8765, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0,         1'b1, 32'hDEAD_BEEF,
                 1'b1, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,         1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00A5, 1'b1, 32'h0,
                 1'b1, 1'b1, 32'h0000_0100, 4'b0010, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0040, 32'h1122_3344, 1'b1, 32'h0,
                 1'b1, 1'b1, 32'h0000_0040, 4'b1111, 32'h1122_3344, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0203, 32'h0000_1111, 1'b1, 32'h0,
                 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1};
    vecs[9]  = '{1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0,         1'b1, 32'h00C3_0000,
                 1'b1, 1'b0, 32'h0000_0100, 4'b0100, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_00C3, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0100, 32'h0,         1'b1, 32'hAABB_CC7F,
                 1'b1, 1'b0, 32'h0000_0100, 4'b0001, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_007F, 1'b0};

    // ---- reset state
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table: each op is presented, latched, then checked in its MEM cycle
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_ex(vecs[i].m2r, vecs[i].rwe, vecs[i].rwi, vecs[i].rd, vecs[i].wr,
               vecs[i].size, vecs[i].sgn, vecs[i].exec, vecs[i].sdata);
      mem_ready = 1'b0;
      @(negedge clk);
      drive_nop();
      mem_ready = vecs[i].ready;
      mem_rdata = vecs[i].rdata;
      #1;
      check($sformatf("v%0d mem_req", i),    mem_req,    vecs[i].x_req);
      check($sformatf("v%0d mem_we", i),     mem_we,     vecs[i].x_we);
      check($sformatf("v%0d mem_addr", i),   mem_addr,   vecs[i].x_addr);
      check($sformatf("v%0d mem_be", i),     mem_be,     vecs[i].x_be);
      check($sformatf("v%0d mem_wdata", i),  mem_wdata,  vecs[i].x_wdata);
      check($sformatf("v%0d stall", i),      stall,      vecs[i].x_stall);
      check($sformatf("v%0d regwr", i),      regwr,      vecs[i].x_regwr);
      check($sformatf("v%0d mem2reg", i),    mem2reg,    vecs[i].x_m2r);
      check($sformatf("v%0d rw", i),         rw,         vecs[i].rwi);
      check($sformatf("v%0d execresult", i), execresult, vecs[i].exec);
      check($sformatf("v%0d dmem", i),       dmem,       vecs[i].x_dmem);
      check($sformatf("v%0d misalign", i),   misalign,   vecs[i].x_mis);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("misalign one-cycle pulse", misalign, 32'd0);

    // ---- signed byte load at 0x103, ready after 3 stalled cycles
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0);
    mem_ready = 1'b0;
    @(negedge clk);
    // Next instruction waits upstream while the load stalls.
    drive_ex(1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0055, 32'h0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("dly%0d stall", k),    stall,    32'd1);
      check($sformatf("dly%0d mem_req", k),  mem_req,  32'd1);
      check($sformatf("dly%0d mem_be", k),   mem_be,   32'b1000);
      check($sformatf("dly%0d mem_addr", k), mem_addr, 32'h0000_0100);
      check($sformatf("dly%0d regwr", k),    regwr,    32'd0);
      check($sformatf("dly%0d mem2reg", k),  mem2reg,  32'd0);
      check($sformatf("dly%0d rw", k),       rw,       32'd5);
    end
    check("dly wait state", dbg_state, 32'd1);
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'h8012_3456;
    #1;
    check("dly done stall", stall, 32'd0);
    check("dly done dmem",  dmem,  32'hFFFF_FF80);
    check("dly done regwr", regwr, 32'd1);
    check("dly done rw",    rw,    32'd5);
    @(negedge clk);
    mem_ready = 1'b0;
    drive_nop();
    #1;
    check("dly next rw",         rw,         32'd4);
    check("dly next execresult", execresult, 32'h0000_0055);
    check("dly next regwr",      regwr,      32'd1);
    check("dly next mem_req",    mem_req,    32'd0);

    // ---- timeout: ready never arrives
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
    mem_ready = 1'b0;
    @(negedge clk);
    drive_nop();
    #1;
    n_stall = 0;
    while (stall === 1'b1 && n_stall < 40) begin
      n_stall++;
      @(negedge clk);
      #1;
    end
    check("to stall cycles", n_stall,   32'd15);
    check("to mem_req",      mem_req,   32'd1);
    check("to regwr bubble", regwr,     32'd0);
    check("to dmem bubble",  dmem,      32'd0);
    check("to fault not yet", mem_fault, 32'd0);
    drive_ex(1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0077, 32'h0);
    @(negedge clk);
    drive_nop();
    #1;
    check("to after fault",      mem_fault,  32'd1);
    check("to after regwr",      regwr,      32'd1);
    check("to after rw",         rw,         32'd2);
    check("to after execresult", execresult, 32'h0000_0077);
    check("to after mem_req",    mem_req,    32'd0);
    check("to after idle",       dbg_state,  32'd0);
    @(negedge clk);
    #1;
    check("to fault sticky", mem_fault, 32'd1);

    // ---- reset taken mid-WAIT
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
    mem_ready = 1'b0;
    @(negedge clk);
    drive_nop();
    #1;
    check("rst pre stall", stall, 32'd1);
    @(negedge clk);
    #1;
    check("rst pre wait", dbg_state, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst mid");
    @(negedge clk);
    rst_n = 1'b1;
    drive_ex(1'b0, 1'b1, 5'd11, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0099, 32'h0);
    @(negedge clk);
    drive_nop();
    #1;
    check("rst post regwr",      regwr,      32'd1);
    check("rst post rw",         rw,         32'd11);
    check("rst post execresult", execresult, 32'h0000_0099);
    check("rst post mem_req",    mem_req,    32'd0);
    check("rst post fault",      mem_fault,  32'd0);

    // ---- report
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage. Sits between execute and the write-back stage.
- Holds the EX/MEM pipeline register and runs byte/half/word loads and stores over a ready-handshaked data-memory port.
- Aligns and sign/zero-extends load data.
- Stalls upstream while an access is outstanding and sends bubbles downstream.
- Outputs feed the write-back stage's own register (mem2reg, regwrite, rw, dmem, execresult).

Parameters:
- TIMEOUT, 16, max wait cycles for mem_ready before the access is abandoned and a fault is flagged.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dmem2reg  in  1  EX: write-back selects memory data.
- dregwr  in  1  EX: register write enable.
- drw  in  5  EX: destination register.
- dmemrd  in  1  EX: load.
- dmemwr  in  1  EX: store.
- dsize  in  2  EX: 00 byte, 01 half, 10 word; 11 is treated as word.
- dsigned  in  1  EX: sign-extend loads.
- dexecresult  in  32  EX: ALU result / effective address.
- dstoredata  in  32  EX: store data.
- stall  out  1  upstream hold.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe.
- mem_addr  out  32  word-aligned address.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  access completes this cycle.
- mem_rdata  in  32  read data, valid when mem_ready=1.
- mem2reg  out  1  to WB.
- regwr  out  1  to WB.
- rw  out  5  to WB.
- dmem  out  32  aligned/extended load data to WB.
- execresult  out  32  to WB.
- misalign  out  1  one-cycle pulse.
- mem_fault  out  1  sticky timeout flag.

Behaviour:
- **Reset** (rst_n low, asynchronous): EX/MEM register cleared (all controls 0, data 0). FSM goes to IDLE, wait counter 0, mem_fault 0. All outputs 0.
  - Reset mid-access drops the request immediately. No retry after reset.
- **EX/MEM register**: captures all d* inputs on a rising edge when stall=0; holds when stall=1.
- **Memory-op flag**: mop = memrd|memwr of the latched instruction, after the alignment check.
- **Alignment**:
  - A half access with addr[0]=1 is misaligned.
  - A word access with addr[1:0]!=0 is misaligned.
  - A misaligned op issues no request, pulses misalign for 1 cycle, and forces regwr=0.
- **FSM**:
  - IDLE: if mop, then mem_req=1. If mem_ready is also 1 that cycle, the access completes with zero stall. Otherwise go to WAIT, and stall=1 this cycle.
  - WAIT: mem_req=1 with mem_addr/mem_we/mem_be/mem_wdata held stable. The counter increments each cycle.
    - On mem_ready: complete, return to IDLE, stall=0.
    - If the counter reaches TIMEOUT-1 without ready: set mem_fault, return to IDLE, stall=0, and issue a bubble (regwr=0, dmem=0).
- **stall**: stall = mem_req & ~mem_ready & ~timeout_hit.
- **Downstream outputs** (combinational from the register):
  - While stall=1: regwr=0 and mem2reg=0 (bubble); the other fields pass through.
  - Otherwise they pass the latched values, with regwr additionally gated by misalign/timeout.
- **Byte enables** (from size and addr[1:0]):
  - byte: 0001<<addr[1:0].
  - half: 0011<<addr[1:0] (addr[1] selects upper).
  - word: 1111.
- **Store data**:
  - byte: replicated to all four lanes.
  - half: replicated to both halves.
  - word: as-is.
- **mem_addr**: {addr[31:2],2'b00}.
- **Load data**:
  - Select the lane by addr[1:0].
  - Zero- or sign-extend to 32 bits per dsigned.
  - Sampled in the completion cycle.
  - dmem is 0 for non-loads.
- **Non-memory instructions**: no request, no stall, single-cycle pass-through.
- **Back-to-back memory ops**: each completes in ≥1 cycle.
- **mem_fault**: cleared only by reset.

Test Plan:
- Reset: pulse rst_n low mid-WAIT -> mem_req=0, stall=0, and all outputs 0 within the same cycle (asynchronous). After release, the first ALU op passes with regwr=1 after 1 edge.
- ALU op (dexecresult=0x1234, drw=7, dregwr=1, mem2reg=0) -> next cycle rw=7, execresult=0x1234, regwr=1, no mem_req.
- Signed byte load at addr 0x103, mem_ready delayed 3 cycles, rdata=0x80xxxxxx -> stall high 3 cycles with mem_be=1000 and mem_addr=0x100; dmem=0xFFFFFF80 on completion; regwr=0 during stall.
- Half store at 0x202, data 0x0000BEEF, ready same cycle -> mem_we=1, mem_be=1100, mem_wdata=0xBEEFBEEF, zero stall.
- Word load at 0x301 -> misalign pulse, no mem_req, regwr=0.
- mem_ready never asserted, TIMEOUT=16 -> stall for 15 cycles, then mem_fault=1 and a bubble; the next ALU op proceeds normally with mem_fault still 1.
